// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared types and helpers for the UART receive/transmit path.
//  Revision    : 1.0  initial release
// ============================================================================
package uart_pkg;

    // Receiver frame state
    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        START      = 3'd1,
        DATA       = 3'd2,
        PARITY     = 3'd3,
        STOP1      = 3'd4,
        STOP2      = 3'd5,
        BREAK_WAIT = 3'd6
    } rx_state_e;

    // Frame format, captured at the start edge of each frame
    typedef struct packed {
        logic [1:0] data_bits;
        logic       parity_en;
        logic       parity_type;
        logic       stop2;
    } uart_cfg_t;

    // Map the 2-bit data-bit code onto a bit count of 5..8
    function automatic logic [3:0] data_bits_to_n(input logic [1:0] bits);
        return 4'd5 + {2'b00, bits};
    endfunction

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_baud_tick.sv
`default_nettype none
// ============================================================================
//  Module      : uart_baud_tick
//  Description : Oversample tick generator. Emits a one-cycle tick every
//                max(div_i,1) clocks; restart_i re-phases the divider.
//  Revision    : 1.0  initial release
// ============================================================================
module uart_baud_tick #(
    parameter int DIV_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             restart_i,
    input  logic [DIV_W-1:0] div_i,
    output logic             tick_o
);

    logic [DIV_W-1:0] r_cnt;
    logic             r_tick;
    logic [DIV_W-1:0] w_div_eff;

    // A divide value of zero behaves like one (tick every cycle)
    assign w_div_eff = (div_i == '0) ? DIV_W'(1) : div_i;

    // Count clocks; the tick fires on the last count of each period
    always_ff @(posedge clk_i) begin
        if (rst_i || restart_i) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else if (r_cnt >= w_div_eff - DIV_W'(1)) begin
            r_cnt  <= '0;
            r_tick <= 1'b1;
        end else begin
            r_cnt  <= r_cnt + DIV_W'(1);
            r_tick <= 1'b0;
        end
    end

    assign tick_o = r_tick;

endmodule : uart_baud_tick
`default_nettype wire

// File: rtl/uart_rx_core.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_core
//  Description : Oversampling UART receiver with 3-sample majority vote,
//                5-8 data bits, optional parity, 1/2 stop bits, break and
//                overrun detection, and a valid/ready output register.
//  Revision    : 1.0  initial release
// ============================================================================
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = 16,
    parameter int DIV_W      = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [DIV_W-1:0] cfg_clk_div_i,
    input  logic [1:0]       cfg_data_bits_i,
    input  logic             cfg_parity_en_i,
    input  logic             cfg_parity_type_i,
    input  logic             cfg_stop2_i,
    input  logic             rx_i,
    output logic [7:0]       data_o,
    output logic             data_valid_o,
    input  logic             data_ready_i,
    output logic             parity_err_o,
    output logic             frame_err_o,
    output logic             break_o,
    output logic             overrun_o,
    output logic             busy_o
);

    localparam int              TCW       = $clog2(OVERSAMPLE);
    localparam logic [TCW-1:0]  c_TC_MAX  = TCW'(OVERSAMPLE - 1);
    localparam logic [TCW-1:0]  c_SMP_LO  = TCW'(OVERSAMPLE / 2 - 1);
    localparam logic [TCW-1:0]  c_SMP_MID = TCW'(OVERSAMPLE / 2);
    localparam logic [TCW-1:0]  c_SMP_HI  = TCW'(OVERSAMPLE / 2 + 1);

    logic             r_rx_meta, r_rx_s, r_rx_prev;
    rx_state_e        r_state;
    uart_cfg_t        r_cfg;
    logic [DIV_W-1:0] r_div;
    logic [TCW-1:0]   r_tick_cnt;
    logic [2:0]       r_bit_idx;
    logic             r_smp0, r_smp1;
    logic [7:0]       r_shift;
    logic             r_par, r_par_err, r_stop_low, r_all_zero;
    logic [7:0]       r_data;
    logic             r_valid, r_perr, r_ferr, r_brk, r_overrun;

    logic             w_start_edge, w_tick, w_vote;
    logic [TCW-1:0]   w_tick_cnt_nxt;
    logic [2:0]       w_last_idx;
    logic             w_frame_done, w_frame_err, w_frame_break;

    // Two-flop synchroniser plus one delayed copy for falling-edge detection
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_meta <= rx_i;
            r_rx_s    <= r_rx_meta;
            r_rx_prev <= r_rx_s;
        end
    end

    assign w_start_edge = (r_state == IDLE) && r_rx_prev && !r_rx_s;

    uart_baud_tick #(
        .DIV_W (DIV_W)
    ) u_baud_tick (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .restart_i (w_start_edge),
        .div_i     (r_div),
        .tick_o    (w_tick)
    );

    assign w_tick_cnt_nxt = (r_tick_cnt == c_TC_MAX) ? '0 : r_tick_cnt + TCW'(1);
    assign w_last_idx     = 3'(data_bits_to_n(r_cfg.data_bits) - 4'd1);
    // The third sample is the live line value; the first two were captured earlier
    assign w_vote         = (r_smp0 & r_smp1) | (r_smp0 & r_rx_s) | (r_smp1 & r_rx_s);
    assign w_frame_done   = w_tick && (r_tick_cnt == c_SMP_HI) &&
                            (((r_state == STOP1) && !r_cfg.stop2) || (r_state == STOP2));
    assign w_frame_err    = r_stop_low | ~w_vote;
    assign w_frame_break  = r_all_zero & ~w_vote;

    // Frame state machine: bit timing, sampling, shifting and error tracking
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= IDLE;
            r_cfg      <= '0;
            r_div      <= '0;
            r_tick_cnt <= '0;
            r_bit_idx  <= '0;
            r_smp0     <= 1'b1;
            r_smp1     <= 1'b1;
            r_shift    <= '0;
            r_par      <= 1'b0;
            r_par_err  <= 1'b0;
            r_stop_low <= 1'b0;
            r_all_zero <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_start_edge) begin
                        r_state    <= START;
                        r_cfg      <= '{data_bits:   cfg_data_bits_i,
                                        parity_en:   cfg_parity_en_i,
                                        parity_type: cfg_parity_type_i,
                                        stop2:       cfg_stop2_i};
                        r_div      <= cfg_clk_div_i;
                        r_tick_cnt <= '0;
                        r_bit_idx  <= '0;
                        r_shift    <= '0;
                        r_par      <= 1'b0;
                        r_par_err  <= 1'b0;
                        r_stop_low <= 1'b0;
                        r_all_zero <= 1'b1;
                    end
                end
                BREAK_WAIT: begin
                    // Hold off new starts until the line has recovered
                    if (r_rx_s) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    if (w_tick) begin
                        r_tick_cnt <= w_tick_cnt_nxt;
                        if (r_tick_cnt == c_SMP_LO) begin
                            r_smp0 <= r_rx_s;
                        end
                        if (r_tick_cnt == c_SMP_MID) begin
                            r_smp1 <= r_rx_s;
                        end
                        if (r_tick_cnt == c_SMP_HI) begin
                            case (r_state)
                                START: begin
                                    r_state <= w_vote ? IDLE : DATA;
                                end
                                DATA: begin
                                    r_shift[r_bit_idx] <= w_vote;
                                    r_par              <= r_par ^ w_vote;
                                    r_all_zero         <= r_all_zero & ~w_vote;
                                    if (r_bit_idx == w_last_idx) begin
                                        r_state <= r_cfg.parity_en ? PARITY : STOP1;
                                    end else begin
                                        r_bit_idx <= r_bit_idx + 3'd1;
                                    end
                                end
                                PARITY: begin
                                    r_par_err  <= w_vote ^ r_par ^ r_cfg.parity_type;
                                    r_all_zero <= r_all_zero & ~w_vote;
                                    r_state    <= STOP1;
                                end
                                STOP1: begin
                                    r_stop_low <= ~w_vote;
                                    r_all_zero <= r_all_zero & ~w_vote;
                                    if (r_cfg.stop2) begin
                                        r_state <= STOP2;
                                    end else begin
                                        r_state <= w_frame_break ? BREAK_WAIT : IDLE;
                                    end
                                end
                                STOP2: begin
                                    r_state <= w_frame_break ? BREAK_WAIT : IDLE;
                                end
                                default: begin
                                    r_state <= IDLE;
                                end
                            endcase
                        end
                    end
                end
            endcase
        end
    end

    // Single-entry output register with valid/ready handshake and overrun pulse
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_perr    <= 1'b0;
            r_ferr    <= 1'b0;
            r_brk     <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            if (w_frame_done) begin
                if (!r_valid || data_ready_i) begin
                    r_data  <= r_shift;
                    r_perr  <= r_par_err;
                    r_ferr  <= w_frame_err;
                    r_brk   <= w_frame_break;
                    r_valid <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_valid && data_ready_i) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign data_o       = r_data;
    assign data_valid_o = r_valid;
    assign parity_err_o = r_perr;
    assign frame_err_o  = r_ferr;
    assign break_o      = r_brk;
    assign overrun_o    = r_overrun;
    assign busy_o       = (r_state != IDLE);

endmodule : uart_rx_core
`default_nettype wire

// File: tb/tb_uart_rx_core.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx_core
//  Description : Scoreboard bench for uart_rx_core: directed frames with
//                hand-computed expected bytes and flags.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_uart_rx_core;

    localparam int DIV   = 8;
    localparam int OVS   = 16;
    localparam int BIT   = DIV * OVS;

    typedef struct packed {
        logic [7:0] d;
        logic       p;
        logic       f;
        logic       b;
    } exp_t;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [15:0] cfg_clk_div_i;
    logic [1:0]  cfg_data_bits_i;
    logic        cfg_parity_en_i;
    logic        cfg_parity_type_i;
    logic        cfg_stop2_i;
    logic        rx_i;
    logic [7:0]  data_o;
    logic        data_valid_o;
    logic        data_ready_i;
    logic        parity_err_o;
    logic        frame_err_o;
    logic        break_o;
    logic        overrun_o;
    logic        busy_o;

    exp_t        exp_q[$];
    int          chk_cnt = 0;
    int          err_cnt = 0;
    int          ovr_seen = 0;

    uart_rx_core #(
        .OVERSAMPLE (OVS),
        .DIV_W      (16)
    ) dut (
        .clk_i             (clk_i),
        .rst_i             (rst_i),
        .cfg_clk_div_i     (cfg_clk_div_i),
        .cfg_data_bits_i   (cfg_data_bits_i),
        .cfg_parity_en_i   (cfg_parity_en_i),
        .cfg_parity_type_i (cfg_parity_type_i),
        .cfg_stop2_i       (cfg_stop2_i),
        .rx_i              (rx_i),
        .data_o            (data_o),
        .data_valid_o      (data_valid_o),
        .data_ready_i      (data_ready_i),
        .parity_err_o      (parity_err_o),
        .frame_err_o       (frame_err_o),
        .break_o           (break_o),
        .overrun_o         (overrun_o),
        .busy_o            (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic expect_frame(input logic [7:0] d, input logic p, input logic f, input logic b);
        exp_q.push_back('{d: d, p: p, f: f, b: b});
    endtask

    // Drive the line to v for n clocks; inputs always change 1 ns after a rising edge
    task automatic hold(input logic v, input int n);
        rx_i = v;
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input int nb, input bit pen,
                              input bit pbit, input int ns, input bit sval);
        hold(1'b0, BIT);
        for (int i = 0; i < nb; i++) hold(d[i], BIT);
        if (pen) hold(pbit, BIT);
        for (int i = 0; i < ns; i++) hold(sval, BIT);
        rx_i = 1'b1;
    endtask

    task automatic set_cfg(input logic [1:0] bits, input logic pen, input logic ptype, input logic s2);
        cfg_data_bits_i   = bits;
        cfg_parity_en_i   = pen;
        cfg_parity_type_i = ptype;
        cfg_stop2_i       = s2;
    endtask

    // Monitor: every accepted byte is compared with the head of the scoreboard
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_i);
            if (!rst_i) begin
                if (overrun_o) ovr_seen++;
                if (data_valid_o && data_ready_i) begin
                    if (exp_q.size() == 0) begin
                        chk_cnt++;
                        err_cnt++;
                        $display("FAIL unexpected_frame: got data 0x%02h p%0b f%0b b%0b, expected none",
                                 data_o, parity_err_o, frame_err_o, break_o);
                    end else begin
                        e = exp_q.pop_front();
                        check("frame {data,perr,ferr,brk}",
                              {21'd0, data_o, parity_err_o, frame_err_o, break_o}, {21'd0, e});
                    end
                end
            end
        end
    end

    // Directed stimulus
    initial begin
        rst_i         = 1'b1;
        rx_i          = 1'b1;
        data_ready_i  = 1'b1;
        cfg_clk_div_i = 16'(DIV);
        set_cfg(2'd3, 1'b0, 1'b0, 1'b0);
        repeat (4) @(posedge clk_i);
        #1;
        check("rst_valid", {31'd0, data_valid_o}, 32'd0);
        check("rst_data", {24'd0, data_o}, 32'd0);
        check("rst_busy", {31'd0, busy_o}, 32'd0);
        check("rst_flags", {28'd0, parity_err_o, frame_err_o, break_o, overrun_o}, 32'd0);
        rst_i = 1'b0;
        hold(1'b1, 20);

        // 8N1 0xA5 held until ready
        data_ready_i = 1'b0;
        expect_frame(8'hA5, 1'b0, 1'b0, 1'b0);
        send_frame(8'hA5, 8, 1'b0, 1'b0, 1, 1'b1);
        hold(1'b1, BIT);
        check("8n1_hold_valid", {31'd0, data_valid_o}, 32'd1);
        check("8n1_hold_data", {24'd0, data_o}, 32'hA5);
        data_ready_i = 1'b1;
        hold(1'b1, 4);
        check("8n1_valid_drop", {31'd0, data_valid_o}, 32'd0);

        // 7O2: 0x35 has four ones, so the odd parity bit is 1
        set_cfg(2'd2, 1'b1, 1'b1, 1'b1);
        expect_frame(8'h35, 1'b0, 1'b0, 1'b0);
        send_frame(8'h35, 7, 1'b1, 1'b1, 2, 1'b1);
        expect_frame(8'h35, 1'b1, 1'b0, 1'b0);
        send_frame(8'h35, 7, 1'b1, 1'b0, 2, 1'b1);
        hold(1'b1, BIT);

        // Framing error: 8N1 0x5A with the stop bit low
        set_cfg(2'd3, 1'b0, 1'b0, 1'b0);
        expect_frame(8'h5A, 1'b0, 1'b1, 1'b0);
        send_frame(8'h5A, 8, 1'b0, 1'b0, 1, 1'b0);
        hold(1'b1, BIT);

        // Break: line low for two frame times, exactly one report
        expect_frame(8'h00, 1'b0, 1'b1, 1'b1);
        hold(1'b0, 20 * BIT);
        check("brk_wait_busy", {31'd0, busy_o}, 32'd1);
        hold(1'b1, 2 * BIT);
        check("brk_idle_busy", {31'd0, busy_o}, 32'd0);

        // Glitch: 3 ticks low on idle is a false start
        hold(1'b0, 3 * DIV);
        check("glitch_busy", {31'd0, busy_o}, 32'd1);
        hold(1'b1, 2 * BIT);
        check("glitch_idle", {31'd0, busy_o}, 32'd0);

        // Overrun: 0x11 then 0x22 back to back without ready
        data_ready_i = 1'b0;
        expect_frame(8'h11, 1'b0, 1'b0, 1'b0);
        send_frame(8'h11, 8, 1'b0, 1'b0, 1, 1'b1);
        send_frame(8'h22, 8, 1'b0, 1'b0, 1, 1'b1);
        hold(1'b1, BIT);
        check("ovr_data_kept", {24'd0, data_o}, 32'h11);
        check("ovr_pulses", 32'(ovr_seen), 32'd1);
        data_ready_i = 1'b1;
        hold(1'b1, 4);
        check("ovr_drained", {31'd0, data_valid_o}, 32'd0);

        // Same-cycle handshake: ready only in the cycle 0x22 completes.
        // Load edge is 4 + (16*9+10)*DIV clocks after the start bit is driven.
        data_ready_i = 1'b0;
        expect_frame(8'h33, 1'b0, 1'b0, 1'b0);
        send_frame(8'h33, 8, 1'b0, 1'b0, 1, 1'b1);
        hold(1'b1, BIT);
        expect_frame(8'h22, 1'b0, 1'b0, 1'b0);
        fork
            send_frame(8'h22, 8, 1'b0, 1'b0, 1, 1'b1);
            begin
                repeat (3 + (16 * 9 + 10) * DIV) @(posedge clk_i);
                #1 data_ready_i = 1'b1;
                @(posedge clk_i);
                #1 data_ready_i = 1'b0;
            end
        join
        hold(1'b1, BIT);
        check("same_cycle_valid", {31'd0, data_valid_o}, 32'd1);
        check("same_cycle_data", {24'd0, data_o}, 32'h22);
        check("same_cycle_no_ovr", 32'(ovr_seen), 32'd1);
        data_ready_i = 1'b1;
        hold(1'b1, 4);

        // Reset in the middle of the data bits of 0xFF
        hold(1'b0, BIT);
        hold(1'b1, 3 * BIT);
        rst_i = 1'b1;
        hold(1'b1, 2);
        check("midrst_valid", {31'd0, data_valid_o}, 32'd0);
        check("midrst_data", {24'd0, data_o}, 32'd0);
        check("midrst_busy", {31'd0, busy_o}, 32'd0);
        check("midrst_flags", {28'd0, parity_err_o, frame_err_o, break_o, overrun_o}, 32'd0);
        rst_i = 1'b0;
        hold(1'b1, BIT);

        // 5-bit mode: 0x0F
        set_cfg(2'd0, 1'b0, 1'b0, 1'b0);
        expect_frame(8'h0F, 1'b0, 1'b0, 1'b0);
        send_frame(8'h0F, 5, 1'b0, 1'b0, 1, 1'b1);
        hold(1'b1, BIT);

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        check("overrun_total", 32'(ovr_seen), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
        $finish;
    end

endmodule : tb_uart_rx_core
`default_nettype wire
